control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 supported.
REQ-002 clk  in  1  clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ir  in  32  current instruction word.
REQ-005 pc  in  32  address of current instruction.
REQ-006 rs1_val  in  32  register-file rs1 data.
REQ-007 rs2_val  in  32  register-file rs2 data.
REQ-008 stall  in  1  bus not ready; freezes FSM.
REQ-009 rd_index/rs1_index/rs2_index  out  5 each  ir[11:7]/ir[19:15]/ir[24:20].
REQ-010 imm  out  32  sign-extended immediate.
REQ-011 f3  out  3  ir[14:12]; memory size/sign.
REQ-012 alu_out  out  32  ALU result; also load/store address and JALR target.
REQ-013 branch_taken  out  1  PC steps by imm instead of 4.
REQ-014 pc_load  out  1  PC loads alu_out with bit0 cleared, write-back only.
REQ-015 dest_reg_from  out  2  0 none, 1 ALU, 2 bus, 3 next PC.
REQ-016 dbus_re/dbus_we  out  1 each  data read/write request.
REQ-017 fetch_next_instruction/load_ir  out  1 each  instruction fetch strobe / IR load enable.
REQ-018 en_pc_counter/write_back_stage  out  1 each  PC advance / register write-back enable.

Function
REQ-019 Decode: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP per RV32I; any other opcode SHALL act as NOP (dest 0, no bus, no branch).
REQ-020 imm SHALL use standard I/S/B/U/J formats by opcode; OP yields 0.
REQ-021 ALU operand A: pc for AUIPC/JAL, else rs1_val; operand B: rs2_val for OP/BRANCH, else imm.
REQ-022 ALU modes: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B (LUI); shifts use B[4:0]; all 32-bit wrap-around.
REQ-023 OP: f7[5] selects SUB/SRA; OP-IMM: f7[5] selects SRAI only, ADDI never subtracts.
REQ-024 LOAD/STORE/JALR/AUIPC/JAL SHALL use ADD.
REQ-025 BRANCH: BEQ/BNE compare equality, BLT/BGE signed, BLTU/BGEU unsigned; branch_taken combinational; JAL always taken.
REQ-026 dest_reg_from: 1 for LUI/AUIPC/OP/OP-IMM, 2 LOAD, 3 JAL/JALR, 0 otherwise.
REQ-027 FSM states FETCH, EXECUTE, WRITEBACK; each advances on clk only when stall=0; WRITEBACK->FETCH unconditionally.
REQ-028 FETCH: fetch_next_instruction=load_ir=1; EXECUTE: dbus_re (LOAD) or dbus_we (STORE); WRITEBACK: write_back_stage=1.
REQ-029 en_pc_counter=1 in WRITEBACK when not JALR; pc_load=1 in WRITEBACK for JALR only.
REQ-030 Decode and ALU outputs purely combinational from ir, pc, rs1_val, rs2_val.

Reset
REQ-031 rst low SHALL force FETCH immediately, including mid-EXECUTE/WRITEBACK; all strobes 0 while low.
REQ-032 First rising clk after release SHALL see FETCH strobes asserted.

Configuration
REQ-033 Macro DUMP_STATE_EN defined: $display state, ir, alu_out on every state change; undefined: no display code compiled, identical RTL.

Structure
REQ-034 Shared package SHALL hold opcode constants, alu_mode_t, dest_reg_from_t, fsm state enum.
REQ-035 Sub-module alu (operands, mode, result) instantiated once.

Verification
REQ-036 ir=0x00500093 (ADDI x1,x0,5), rs1_val=0 -> rd_index=1, imm=5, alu_out=5, dest_reg_from=1.
REQ-037 ir=0x402081B3 (SUB x3,x1,x2), rs1_val=10, rs2_val=3 -> alu_out=7.
REQ-038 ir=0x00208463 (BEQ +8), rs1_val=rs2_val=4 -> imm=8, branch_taken=1; rs2_val=5 -> 0.
REQ-039 ir=0x4040D093 (SRAI 4), rs1_val=0x80000000 -> alu_out=0xF8000000; ir=0x123452B7 -> alu_out=0x12345000.
REQ-040 LOAD with stall=1 for 3 cycles -> EXECUTE held, dbus_re=1 throughout; rst low mid-EXECUTE -> FETCH, strobes 0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: RV32I opcode constants, ALU mode,
// write-back source selector, FSM state encoding and the funct3-to-ALU helper.
package control_unit_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_mode_t;

  typedef enum logic [1:0] {
    DEST_NONE    = 2'd0,
    DEST_ALU     = 2'd1,
    DEST_BUS     = 2'd2,
    DEST_NEXT_PC = 2'd3
  } dest_reg_from_t;

  typedef enum logic [1:0] {
    FETCH,
    EXECUTE,
    WRITEBACK
  } state_t;

  // Arithmetic operation for OP / OP-IMM; 'alt' is the funct7[5] select,
  // already qualified by the caller so ADDI can never turn into a subtract.
  function automatic alu_mode_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_alu.sv
// Combinational ALU for the control unit. All results wrap at XLEN bits and
// shift amounts come from the low five bits of operand b.
module control_unit_alu
  import control_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      mode,
  output logic [XLEN-1:0] result
);

  // Select the operation result for the requested mode.
  always_comb begin
    result = '0;
    case (alu_mode_t'(mode))
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << b[4:0];
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> b[4:0];
      ALU_SRA:    result = XLEN'($signed(a) >>> b[4:0]);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RV32I control unit: combinational decode, immediate generation, ALU and
// branch evaluation, plus a FETCH/EXECUTE/WRITEBACK sequencer frozen by stall.
// Optional macro DUMP_STATE_EN prints state, ir and alu_out on state changes.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ir,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            stall,
  output logic [4:0]      rd_index,
  output logic [4:0]      rs1_index,
  output logic [4:0]      rs2_index,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      f3,
  output logic [XLEN-1:0] alu_out,
  output logic            branch_taken,
  output logic            pc_load,
  output logic [1:0]      dest_reg_from,
  output logic            dbus_re,
  output logic            dbus_we,
  output logic            fetch_next_instruction,
  output logic            load_ir,
  output logic            en_pc_counter,
  output logic            write_back_stage
);

  logic [6:0]     opcode;
  logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
  logic           use_pc_a, use_rs2_b;
  alu_mode_t      mode;
  dest_reg_from_t dest;
  logic [XLEN-1:0] op_a, op_b;
  logic           is_load, is_store, is_jalr;
  state_t         state, state_next;

  assign opcode    = ir[6:0];
  assign rd_index  = ir[11:7];
  assign rs1_index = ir[19:15];
  assign rs2_index = ir[24:20];
  assign f3        = ir[14:12];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'h000};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_jalr  = (opcode == OPC_JALR);

  // Decode opcode into immediate format, operand sources, ALU mode and write-back source.
  always_comb begin
    imm       = '0;
    use_pc_a  = 1'b0;
    use_rs2_b = 1'b0;
    mode      = ALU_ADD;
    dest      = DEST_NONE;
    case (opcode)
      OPC_LUI: begin
        imm  = imm_u;
        mode = ALU_PASS_B;
        dest = DEST_ALU;
      end
      OPC_AUIPC: begin
        imm      = imm_u;
        use_pc_a = 1'b1;
        dest     = DEST_ALU;
      end
      OPC_JAL: begin
        imm      = imm_j;
        use_pc_a = 1'b1;
        dest     = DEST_NEXT_PC;
      end
      OPC_JALR: begin
        imm  = imm_i;
        dest = DEST_NEXT_PC;
      end
      OPC_BRANCH: begin
        imm       = imm_b;
        use_rs2_b = 1'b1;
        mode      = ALU_SUB;
      end
      OPC_LOAD: begin
        imm  = imm_i;
        dest = DEST_BUS;
      end
      OPC_STORE: begin
        imm = imm_s;
      end
      OPC_OP_IMM: begin
        imm  = imm_i;
        mode = alu_from_f3(ir[14:12], ir[30] && (ir[14:12] == 3'b101));
        dest = DEST_ALU;
      end
      OPC_OP: begin
        use_rs2_b = 1'b1;
        mode      = alu_from_f3(ir[14:12], ir[30]);
        dest      = DEST_ALU;
      end
      default: begin
      end
    endcase
  end

  assign op_a          = use_pc_a ? pc : rs1_val;
  assign op_b          = use_rs2_b ? rs2_val : imm;
  assign dest_reg_from = dest;

  control_unit_alu #(.XLEN(XLEN)) alu (
    .a      (op_a),
    .b      (op_b),
    .mode   (mode),
    .result (alu_out)
  );

  // Evaluate the branch condition directly on the register operands; JAL is always taken.
  always_comb begin
    branch_taken = 1'b0;
    if (opcode == OPC_JAL) begin
      branch_taken = 1'b1;
    end else if (opcode == OPC_BRANCH) begin
      case (ir[14:12])
        3'b000:  branch_taken = (rs1_val == rs2_val);
        3'b001:  branch_taken = (rs1_val != rs2_val);
        3'b100:  branch_taken = ($signed(rs1_val) < $signed(rs2_val));
        3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
        3'b110:  branch_taken = (rs1_val < rs2_val);
        3'b111:  branch_taken = (rs1_val >= rs2_val);
        default: branch_taken = 1'b0;
      endcase
    end
  end

  // Sequencer state register; reset forces FETCH at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and stage strobes; all strobes held low while reset is asserted.
  always_comb begin
    state_next             = state;
    fetch_next_instruction = 1'b0;
    load_ir                = 1'b0;
    dbus_re                = 1'b0;
    dbus_we                = 1'b0;
    write_back_stage       = 1'b0;
    en_pc_counter          = 1'b0;
    pc_load                = 1'b0;
    if (rst) begin
      case (state)
        FETCH: begin
          fetch_next_instruction = 1'b1;
          load_ir                = 1'b1;
          if (!stall) state_next = EXECUTE;
        end
        EXECUTE: begin
          dbus_re = is_load;
          dbus_we = is_store;
          if (!stall) state_next = WRITEBACK;
        end
        WRITEBACK: begin
          write_back_stage = 1'b1;
          en_pc_counter    = !is_jalr;
          pc_load          = is_jalr;
          if (!stall) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

`ifdef DUMP_STATE_EN
  // Trace each state transition with the instruction and ALU result in flight.
  always @(posedge clk) begin
    if (rst && (state_next != state)) begin
      $display("control_unit: state %s -> %s ir=%08h alu_out=%08h",
               state.name(), state_next.name(), ir, alu_out);
    end
  end
`else
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: reset and sequencer corner cases,
// a directed vector table, then randomized instructions against a reference model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ir = '0, pc = '0, rs1_val = '0, rs2_val = '0;
  logic        stall = 1'b0;
  logic [4:0]  rd_index, rs1_index, rs2_index;
  logic [31:0] imm, alu_out;
  logic [2:0]  f3;
  logic        branch_taken, pc_load, dbus_re, dbus_we;
  logic        fetch_next_instruction, load_ir, en_pc_counter, write_back_stage;
  logic [1:0]  dest_reg_from;

  int checks = 0;
  int failures = 0;

  control_unit #(.XLEN(32)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .ir                     (ir),
    .pc                     (pc),
    .rs1_val                (rs1_val),
    .rs2_val                (rs2_val),
    .stall                  (stall),
    .rd_index               (rd_index),
    .rs1_index              (rs1_index),
    .rs2_index              (rs2_index),
    .imm                    (imm),
    .f3                     (f3),
    .alu_out                (alu_out),
    .branch_taken           (branch_taken),
    .pc_load                (pc_load),
    .dest_reg_from          (dest_reg_from),
    .dbus_re                (dbus_re),
    .dbus_we                (dbus_we),
    .fetch_next_instruction (fetch_next_instruction),
    .load_ir                (load_ir),
    .en_pc_counter          (en_pc_counter),
    .write_back_stage       (write_back_stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        taken;
    logic [1:0]  dest;
    bit          chk_imm;
    bit          chk_alu;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] a, input logic [31:0] b);
    ir = i;
    pc = p;
    rs1_val = a;
    rs2_val = b;
    #1;
  endtask

  // Strobes in order {fetch, load_ir, dbus_re, dbus_we, write_back, en_pc, pc_load}
  function automatic logic [6:0] expStrobes(input int phase, input logic [6:0] opc);
    case (phase)
      0:       return 7'b1100000;
      1:       return {2'b00, opc == 7'h03, opc == 7'h23, 3'b000};
      default: return {4'b0000, 1'b1, opc != 7'h67, opc == 7'h67};
    endcase
  endfunction

  task automatic checkStrobes(input string name, input logic [6:0] expected);
    checkOutput(name,
                {25'd0, fetch_next_instruction, load_ir, dbus_re, dbus_we,
                 write_back_stage, en_pc_counter, pc_load},
                {25'd0, expected});
  endtask

  function automatic logic [31:0] arith(input logic [2:0] fn, input logic alt,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (fn)
      3'd0: r = alt ? x - y : x + y;
      3'd1: r = x << y[4:0];
      3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: r = (x < y) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd5: begin
        if (alt) r = 32'($signed(x) >>> y[4:0]);
        else     r = x >> y[4:0];
      end
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  // Instruction semantics from the ISA description: immediates, result, branch, destination.
  task automatic refModel(input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] e_imm, output logic [31:0] e_alu,
                          output logic e_taken, output logic [1:0] e_dest,
                          output bit c_imm, output bit c_alu);
    logic [2:0] fn;
    fn = i[14:12];
    e_imm = '0; e_alu = '0; e_taken = 1'b0; e_dest = 2'd0; c_imm = 1'b1; c_alu = 1'b1;
    case (i[6:0])
      7'h37: begin e_imm = {i[31:12], 12'h0}; e_alu = e_imm; e_dest = 2'd1; end
      7'h17: begin e_imm = {i[31:12], 12'h0}; e_alu = p + e_imm; e_dest = 2'd1; end
      7'h6F: begin
        e_imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        e_alu = p + e_imm; e_taken = 1'b1; e_dest = 2'd3;
      end
      7'h67: begin e_imm = 32'($signed(i[31:20])); e_alu = a + e_imm; e_dest = 2'd3; end
      7'h63: begin
        e_imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        c_alu = 1'b0;
        case (fn)
          3'd0: e_taken = (a == b);
          3'd1: e_taken = (a != b);
          3'd4: e_taken = ($signed(a) < $signed(b));
          3'd5: e_taken = ($signed(a) >= $signed(b));
          3'd6: e_taken = (a < b);
          3'd7: e_taken = (a >= b);
          default: e_taken = 1'b0;
        endcase
      end
      7'h03: begin e_imm = 32'($signed(i[31:20])); e_alu = a + e_imm; e_dest = 2'd2; end
      7'h23: begin e_imm = 32'($signed({i[31:25], i[11:7]})); e_alu = a + e_imm; end
      7'h13: begin
        e_imm = 32'($signed(i[31:20]));
        e_alu = arith(fn, (fn == 3'd5) && i[30], a, e_imm);
        e_dest = 2'd1;
      end
      7'h33: begin e_imm = '0; e_alu = arith(fn, i[30], a, b); e_dest = 2'd1; end
      default: begin c_imm = 1'b0; c_alu = 1'b0; end
    endcase
  endtask

  vec_t vecs[12];
  logic [31:0] prog[5];
  logic [6:0]  ops[11];

  initial begin
    logic [31:0] e_imm, e_alu, ri, ra, rb, rp;
    logic        e_taken;
    logic [1:0]  e_dest;
    bit          c_imm, c_alu;
    logic [6:0]  opc;

    vecs[0]  = '{32'h00500093, 32'h0, 32'd0, 32'd0, 5'd1, 32'd5, 32'd5, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[1]  = '{32'h402081B3, 32'h0, 32'd10, 32'd3, 5'd3, 32'd0, 32'd7, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[2]  = '{32'h00208463, 32'h0, 32'd4, 32'd4, 5'd8, 32'd8, 32'd0, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{32'h00208463, 32'h0, 32'd4, 32'd5, 5'd8, 32'd8, 32'd0, 1'b0, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{32'h4040D093, 32'h0, 32'h80000000, 32'd0, 5'd1, 32'h404, 32'hF8000000, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[5]  = '{32'h123452B7, 32'h0, 32'd0, 32'd0, 5'd5, 32'h12345000, 32'h12345000, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[6]  = '{32'h010000EF, 32'h100, 32'd0, 32'd0, 5'd1, 32'd16, 32'h110, 1'b1, 2'd3, 1'b1, 1'b1};
    vecs[7]  = '{32'h00001117, 32'h200, 32'd0, 32'd0, 5'd2, 32'h1000, 32'h1200, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[8]  = '{32'hFFC0A183, 32'h0, 32'h1000, 32'd0, 5'd3, 32'hFFFFFFFC, 32'hFFC, 1'b0, 2'd2, 1'b1, 1'b1};
    vecs[9]  = '{32'h0000007F, 32'h0, 32'd1, 32'd1, 5'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{32'h0020E463, 32'h0, 32'd1, 32'hFFFFFFFF, 5'd8, 32'd8, 32'd0, 1'b1, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{32'h0020C463, 32'h0, 32'd1, 32'hFFFFFFFF, 5'd8, 32'd8, 32'd0, 1'b0, 2'd0, 1'b1, 1'b0};

    prog = '{32'hFFC0A183, 32'h0020A423, 32'h000280E7, 32'h00500093, 32'h0000007F};
    ops  = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    // Reset held low: every strobe quiet, even across a clock edge.
    stall = 1'b0;
    rst = 1'b0;
    applyStimulus(32'hFFC0A183, 32'h0, 32'h0, 32'h0);
    checkStrobes("reset_low", 7'd0);
    @(posedge clk); #1;
    checkStrobes("reset_low_edge", 7'd0);
    rst = 1'b1;
    #1;
    checkStrobes("release_fetch", expStrobes(0, 7'h03));

    // Walk a short program through the three stages, with stalls in FETCH and EXECUTE.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(prog[k], 32'h0, 32'h1000, 32'h0);
      opc = prog[k][6:0];
      for (int ph = 0; ph < 3; ph++) begin
        checkStrobes($sformatf("fsm_i%0d_ph%0d", k, ph), expStrobes(ph, opc));
        if ((k == 0 && ph == 1) || (k == 1 && ph == 0)) begin
          stall = 1'b1;
          repeat (3) begin
            @(posedge clk); #1;
            checkStrobes($sformatf("stall_i%0d_ph%0d", k, ph), expStrobes(ph, opc));
          end
          stall = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    checkStrobes("fsm_wrap_fetch", expStrobes(0, 7'h13));

    // Reset pulled mid-EXECUTE of a load.
    applyStimulus(32'hFFC0A183, 32'h0, 32'h1000, 32'h0);
    @(posedge clk); #1;
    checkStrobes("pre_rst_exec", expStrobes(1, 7'h03));
    rst = 1'b0; #1;
    checkStrobes("rst_mid_exec", 7'd0);
    @(posedge clk); #1;
    checkStrobes("rst_mid_exec_edge", 7'd0);
    rst = 1'b1; #1;
    checkStrobes("rst_exec_release", expStrobes(0, 7'h03));
    @(posedge clk); #1;
    checkStrobes("rst_exec_resume", expStrobes(1, 7'h03));

    // Reset pulled mid-WRITEBACK of a JALR.
    applyStimulus(32'h000280E7, 32'h0, 32'h1000, 32'h0);
    @(posedge clk); #1;
    checkStrobes("pre_rst_wb", expStrobes(2, 7'h67));
    rst = 1'b0; #1;
    checkStrobes("rst_mid_wb", 7'd0);
    rst = 1'b1; #1;
    checkStrobes("rst_wb_release", expStrobes(0, 7'h67));

    // Directed decode/ALU vectors.
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].ir, vecs[v].pc, vecs[v].a, vecs[v].b);
      checkOutput($sformatf("vec%0d_rd", v), {27'd0, rd_index}, {27'd0, vecs[v].rd});
      checkOutput($sformatf("vec%0d_taken", v), {31'd0, branch_taken}, {31'd0, vecs[v].taken});
      checkOutput($sformatf("vec%0d_dest", v), {30'd0, dest_reg_from}, {30'd0, vecs[v].dest});
      if (vecs[v].chk_imm) checkOutput($sformatf("vec%0d_imm", v), imm, vecs[v].imm);
      if (vecs[v].chk_alu) checkOutput($sformatf("vec%0d_alu", v), alu_out, vecs[v].alu);
    end

    // Randomized instructions against the reference model.
    for (int n = 0; n < 300; n++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(0, 10)];
      if (ri[6:0] == 7'h33) ri[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      if (ri[6:0] == 7'h13 && ri[14:12] == 3'd1) ri[31:25] = 7'h00;
      if (ri[6:0] == 7'h13 && ri[14:12] == 3'd5) ri[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rp = $urandom & 32'hFFFFFFFC;
      applyStimulus(ri, rp, ra, rb);
      refModel(ri, rp, ra, rb, e_imm, e_alu, e_taken, e_dest, c_imm, c_alu);
      checkOutput($sformatf("rnd%0d_idx", n), {17'd0, rd_index, rs1_index, rs2_index},
                  {17'd0, ri[11:7], ri[19:15], ri[24:20]});
      checkOutput($sformatf("rnd%0d_f3", n), {29'd0, f3}, {29'd0, ri[14:12]});
      checkOutput($sformatf("rnd%0d_taken", n), {31'd0, branch_taken}, {31'd0, e_taken});
      checkOutput($sformatf("rnd%0d_dest", n), {30'd0, dest_reg_from}, {30'd0, e_dest});
      if (c_imm) checkOutput($sformatf("rnd%0d_imm ir=%08h", n, ri), imm, e_imm);
      if (c_alu) checkOutput($sformatf("rnd%0d_alu ir=%08h", n, ri), alu_out, e_alu);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
